// File: rtl/timer_ctrl_if.sv
// Signal bundle between the timer control sequencer and the board/digit chain.
// Inputs are raw board levels or cnt_zero; outputs are registered one-cycle strobes and levels.
interface timer_ctrl_if;
    // No valid/ready pairs: every strobe is a single-cycle pulse that the digit chain
    // must consume in the cycle it is high, and no backpressure exists.
    logic       btn_start;
    logic       btn_plus;
    logic       sw_preset;
    logic       cnt_zero;
    logic       tick_en;
    logic       load_preset;
    logic       preset_inc;
    logic       alarm;
    logic       blank;
    logic [2:0] state;

    modport master (
        input  btn_start, btn_plus, sw_preset, cnt_zero,
        output tick_en, load_preset, preset_inc, alarm, blank, state
    );

    modport slave (
        output btn_start, btn_plus, sw_preset, cnt_zero,
        input  tick_en, load_preset, preset_inc, alarm, blank, state
    );
endinterface

// File: rtl/timer_ctrl_fsm.sv
// Stopwatch/countdown control sequencer: input sync + debounce, IDLE/PRESET/RUN/PAUSE/ALARM
// FSM, and the tick/load/increment strobes plus alarm/blink outputs for the digit chain.
module timer_ctrl_fsm #(
    parameter int TICK_DIV    = 5000000,
    parameter int DEB_CYCLES  = 1000000,
    parameter int ALARM_TICKS = 50,
    parameter int BLINK_TICKS = 5
) (
    input logic          clk_org,
    input logic          reset,
    timer_ctrl_if.master bus
);
    localparam int PW = (TICK_DIV    > 1) ? $clog2(TICK_DIV)    : 1;
    localparam int DW = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
    localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_TERM = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_TERM   = DW'(DEB_CYCLES - 1);
    localparam logic [AW-1:0] ALARM_TERM = AW'(ALARM_TICKS - 1);
    localparam logic [BW-1:0] BLINK_TERM = BW'(BLINK_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESET = 3'd1,
        RUN    = 3'd2,
        PAUSE  = 3'd3,
        ALARM  = 3'd4
    } state_t;

    // Index 0 = start button, index 1 = plus button (both active-low).
    logic [1:0]    btn_s1, btn_s2, btn_deb, btn_evt;
    logic [DW-1:0] deb_cnt [2];
    logic          sw_s1, sw_s2;
    logic          start_evt, plus_evt, sw_sync;

    // The switch synchronizer resets to 0 so a reset never forces a spurious PRESET visit.
    always_ff @(posedge clk_org or negedge reset) begin
        if (!reset) begin
            btn_s1     <= '1;
            btn_s2     <= '1;
            btn_deb    <= '1;
            btn_evt    <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
            sw_s1      <= 1'b0;
            sw_s2      <= 1'b0;
        end else begin
            btn_s1 <= {bus.btn_plus, bus.btn_start};
            btn_s2 <= btn_s1;
            sw_s1  <= bus.sw_preset;
            sw_s2  <= sw_s1;
            for (int i = 0; i < 2; i++) begin
                btn_evt[i] <= 1'b0;
                if (btn_s2[i] == btn_deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_TERM) begin
                    deb_cnt[i] <= '0;
                    btn_deb[i] <= btn_s2[i];
                    btn_evt[i] <= ~btn_s2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign start_evt = btn_evt[0];
    assign plus_evt  = btn_evt[1];
    assign sw_sync   = sw_s2;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d, presc_nxt;
    logic [AW-1:0] acnt_q, acnt_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          presc_wrap;
    logic          blank_q, blank_d, tick_q, tick_d, load_q, load_d;
    logic          inc_q, inc_d, alarm_q, alarm_d;

    assign presc_wrap = (presc_q == PRESC_TERM);
    assign presc_nxt  = presc_wrap ? '0 : presc_q + 1'b1;

    always_ff @(posedge clk_org or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            acnt_q  <= '0;
            blink_q <= '0;
            blank_q <= 1'b0;
            tick_q  <= 1'b0;
            load_q  <= 1'b0;
            inc_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            acnt_q  <= acnt_d;
            blink_q <= blink_d;
            blank_q <= blank_d;
            tick_q  <= tick_d;
            load_q  <= load_d;
            inc_q   <= inc_d;
            alarm_q <= alarm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        acnt_d  = acnt_q;
        blink_d = blink_q;
        blank_d = blank_q;
        load_d  = 1'b0;
        inc_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sw_sync) begin
                    state_d = PRESET;
                end else if (start_evt && !bus.cnt_zero) begin
                    state_d = RUN;
                    presc_d = '0;
                end
            end
            PRESET: begin
                inc_d = plus_evt;
                if (!sw_sync) begin
                    state_d = IDLE;
                    load_d  = 1'b1;
                end
            end
            RUN: begin
                presc_d = presc_nxt;
                // ALARM starts with a fresh prescaler so its tick cadence is phase-independent.
                if (bus.cnt_zero) begin
                    state_d = ALARM;
                    presc_d = '0;
                end else if (start_evt) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (sw_sync) begin
                    state_d = PRESET;
                end else if (start_evt) begin
                    state_d = RUN;
                end
            end
            ALARM: begin
                presc_d = presc_nxt;
                if (start_evt || (presc_wrap && acnt_q == ALARM_TERM)) begin
                    state_d = IDLE;
                    load_d  = 1'b1;
                    presc_d = '0;
                    acnt_d  = '0;
                    blink_d = '0;
                    blank_d = 1'b0;
                end else if (presc_wrap) begin
                    acnt_d = acnt_q + 1'b1;
                    if (blink_q == BLINK_TERM) begin
                        blink_d = '0;
                        blank_d = ~blank_q;
                    end else begin
                        blink_d = blink_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        tick_d  = (state_d == RUN) && (presc_d == PRESC_TERM);
        alarm_d = (state_d == ALARM);
    end

    assign bus.tick_en     = tick_q;
    assign bus.load_preset = load_q;
    assign bus.preset_inc  = inc_q;
    assign bus.alarm       = alarm_q;
    assign bus.blank       = blank_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// Bench for timer_ctrl_fsm: directed vector table, hand-written corner sequences and
// randomized stimulus against a cycle-count reference model of the control rules.
module tb_timer_ctrl_fsm;
  localparam int TD  = 4;
  localparam int DEB = 3;
  localparam int AT  = 6;
  localparam int BT  = 2;

  // ---------------- clock / reset ----------------
  logic clk_org = 1'b0;
  logic reset;
  always #5 clk_org = ~clk_org;

  timer_ctrl_if bus();

  timer_ctrl_fsm #(
    .TICK_DIV(TD), .DEB_CYCLES(DEB), .ALARM_TICKS(AT), .BLINK_TICKS(BT)
  ) dut (
    .clk_org(clk_org),
    .reset(reset),
    .bus(bus)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int n_tick, n_load, n_inc;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int out_vec();
    return int'({bus.state, bus.tick_en, bus.load_preset, bus.preset_inc, bus.alarm, bus.blank});
  endfunction

  // ---------------- reference model ----------------
  // Mode numbers follow the published encoding; time is tracked as plain cycle counts:
  // m_run = RUN cycles since the run was started, m_ak = cycles spent in ALARM.
  int   m_mode, m_run, m_ak;
  bit   m_deb[2];
  bit   m_evt[2];
  bit   hs[$], hp[$], hw[$];
  logic [2:0] e_state;
  bit   e_tick, e_load, e_inc, e_alarm, e_blank;

  function automatic void model_reset();
    m_mode = 0; m_run = 0; m_ak = 0;
    m_deb[0] = 1'b1; m_deb[1] = 1'b1;
    m_evt[0] = 1'b0; m_evt[1] = 1'b0;
    hs.delete(); hp.delete(); hw.delete();
    for (int i = 0; i < 8; i++) begin
      hs.push_back(1'b1); hp.push_back(1'b1); hw.push_back(1'b0);
    end
    e_state = 3'd0; e_tick = 0; e_load = 0; e_inc = 0; e_alarm = 0; e_blank = 0;
  endfunction

  // Predicts the outputs registered at the coming edge from the inputs held before it.
  function automatic void model_step(input bit st, input bit pl, input bit sw, input bit cz);
    int n;
    bit se, pe, sws, all_s, all_p;
    hs.push_back(st); hp.push_back(pl); hw.push_back(sw);
    if (hs.size() > 16) begin
      void'(hs.pop_front()); void'(hp.pop_front()); void'(hw.pop_front());
    end
    n   = hs.size();
    se  = m_evt[0];
    pe  = m_evt[1];
    sws = hw[n-3];
    e_load = 0;
    e_inc  = 0;
    case (m_mode)
      0: if (sws) m_mode = 1;
         else if (se && !cz) begin m_mode = 2; m_run = 0; end
      1: begin
           if (pe) e_inc = 1;
           if (!sws) begin m_mode = 0; e_load = 1; end
         end
      2: begin
           m_run++;
           if (cz) begin m_mode = 4; m_ak = 0; end
           else if (se) m_mode = 3;
         end
      3: if (sws) m_mode = 1;
         else if (se) m_mode = 2;
      4: if (se || m_ak == TD*AT-1) begin m_mode = 0; e_load = 1; end
         else m_ak++;
      default: m_mode = 0;
    endcase
    e_state = 3'(m_mode);
    e_tick  = (m_mode == 2) && (m_run % TD == TD-1);
    e_alarm = (m_mode == 4);
    e_blank = (m_mode == 4) && (((m_ak / TD) / BT) % 2 == 1);
    // A level is accepted once the last DEB synchronized samples all disagree with it.
    all_s = 1; all_p = 1;
    for (int i = 2; i <= DEB+1; i++) begin
      if (hs[n-1-i] == m_deb[0]) all_s = 0;
      if (hp[n-1-i] == m_deb[1]) all_p = 0;
    end
    m_evt[0] = 0; m_evt[1] = 0;
    if (all_s) begin m_deb[0] = !m_deb[0]; m_evt[0] = !m_deb[0]; end
    if (all_p) begin m_deb[1] = !m_deb[1]; m_evt[1] = !m_deb[1]; end
  endfunction

  // ---------------- driver ----------------
  task automatic apply(input bit st, input bit pl, input bit sw, input bit cz);
    bus.btn_start = st;
    bus.btn_plus  = pl;
    bus.sw_preset = sw;
    bus.cnt_zero  = cz;
    if (reset) model_step(st, pl, sw, cz);
    else model_reset();
    exp_q.push_back({e_state, e_tick, e_load, e_inc, e_alarm, e_blank});
    @(posedge clk_org);
    #1;
    check("outputs", out_vec(), int'(exp_q.pop_front()));
    n_tick += int'(bus.tick_en);
    n_load += int'(bus.load_preset);
    n_inc  += int'(bus.preset_inc);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit st, pl, sw, cz;
    int cycles;
    int exp_state, exp_ticks, exp_incs, exp_loads;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit st, input bit pl, input bit sw, input bit cz, input int cyc,
                     input int es, input int et, input int ei, input int el);
    vec_t v;
    v.st = st; v.pl = pl; v.sw = sw; v.cz = cz; v.cycles = cyc;
    v.exp_state = es; v.exp_ticks = et; v.exp_incs = ei; v.exp_loads = el;
    tbl.push_back(v);
  endtask

  bit r_st, r_pl, r_sw, r_cz;
  int h_st, h_pl, h_sw, h_cz;

  initial begin
    //   st pl sw cz cyc  state ticks incs loads
    add(1, 1, 0, 0, 4,   0, 0, 0, 0);  // idle
    add(0, 1, 0, 0, 2,   0, 0, 0, 0);  // 2-cycle bounce rejected
    add(1, 1, 0, 0, 6,   0, 0, 0, 0);
    add(1, 1, 1, 0, 5,   1, 0, 0, 0);  // enter PRESET
    add(0, 1, 1, 0, 6,   1, 0, 0, 0);  // start ignored in PRESET
    add(1, 1, 1, 0, 6,   1, 0, 0, 0);
    add(1, 0, 1, 0, 6,   1, 0, 1, 0);  // plus press 1
    add(1, 1, 1, 0, 6,   1, 0, 0, 0);
    add(1, 0, 1, 0, 6,   1, 0, 1, 0);  // plus press 2
    add(1, 1, 1, 0, 6,   1, 0, 0, 0);
    add(1, 0, 1, 0, 6,   1, 0, 1, 0);  // plus press 3
    add(1, 1, 1, 0, 6,   1, 0, 0, 0);
    add(1, 1, 0, 0, 5,   0, 0, 0, 1);  // leave PRESET with load
    add(0, 1, 0, 0, 6,   2, 0, 0, 0);  // start -> RUN
    add(1, 1, 0, 0, 12,  2, 3, 0, 0);  // tick every 4th cycle
    add(0, 1, 0, 0, 6,   3, 1, 0, 0);  // -> PAUSE
    add(1, 1, 0, 0, 10,  3, 0, 0, 0);  // paused: no ticks
    add(0, 1, 0, 0, 6,   2, 0, 0, 0);  // resume
    add(1, 1, 0, 0, 6,   2, 2, 0, 0);  // held phase preserved
    add(1, 1, 0, 1, 1,   4, 0, 0, 0);  // cnt_zero -> ALARM
    add(1, 1, 0, 1, 24,  0, 0, 0, 1);  // auto-return after ALARM_TICKS ticks
    add(0, 1, 0, 1, 6,   0, 0, 0, 0);  // start with cnt_zero ignored
    add(1, 1, 0, 0, 6,   0, 0, 0, 0);

    reset = 1'b0;
    bus.btn_start = 1'b1; bus.btn_plus = 1'b1; bus.sw_preset = 1'b0; bus.cnt_zero = 1'b0;
    n_tick = 0; n_load = 0; n_inc = 0;
    model_reset();
    repeat (2) @(posedge clk_org);
    #1;
    check("reset_outputs", out_vec(), 0);
    reset = 1'b1;

    foreach (tbl[r]) begin
      n_tick = 0; n_load = 0; n_inc = 0;
      for (int c = 0; c < tbl[r].cycles; c++) apply(tbl[r].st, tbl[r].pl, tbl[r].sw, tbl[r].cz);
      check($sformatf("row%0d_state", r), int'(bus.state), tbl[r].exp_state);
      check($sformatf("row%0d_ticks", r), n_tick, tbl[r].exp_ticks);
      check($sformatf("row%0d_incs", r), n_inc, tbl[r].exp_incs);
      check($sformatf("row%0d_loads", r), n_load, tbl[r].exp_loads);
    end

    // cnt_zero arrives in the same cycle as start_evt: ALARM wins, then blink and auto-exit.
    repeat (6) apply(0, 1, 0, 0);
    check("h1_run", int'(bus.state), 2);
    repeat (6) apply(1, 1, 0, 0);
    repeat (5) apply(0, 1, 0, 0);
    apply(0, 1, 0, 1);
    check("h1_state", int'(bus.state), 4);
    check("h1_alarm", int'(bus.alarm), 1);
    check("h1_tick", int'(bus.tick_en), 0);
    for (int k = 1; k <= 24; k++) begin
      apply(1, 1, 0, 0);
      if (k < 24) begin
        check("h1_blank", int'(bus.blank), (k / 8) % 2);
        check("h1_in_alarm", int'(bus.state), 4);
      end else begin
        check("h1_exit_state", int'(bus.state), 0);
        check("h1_exit_load", int'(bus.load_preset), 1);
        check("h1_exit_alarm", int'(bus.alarm), 0);
      end
    end

    // Start press during ALARM exits at once.
    repeat (6) apply(0, 1, 0, 0);
    repeat (6) apply(1, 1, 0, 0);
    apply(1, 1, 0, 1);
    check("h2_alarm", int'(bus.state), 4);
    n_load = 0;
    repeat (6) apply(0, 1, 0, 0);
    check("h2_state", int'(bus.state), 0);
    check("h2_alarm_off", int'(bus.alarm), 0);
    check("h2_load_now", int'(bus.load_preset), 1);
    check("h2_load_count", n_load, 1);
    repeat (6) apply(1, 1, 0, 0);

    // Asynchronous reset between edges while running.
    repeat (6) apply(0, 1, 0, 0);
    repeat (6) apply(1, 1, 0, 0);
    check("h3_running", int'(bus.state), 2);
    #3;
    reset = 1'b0;
    #1;
    check("h3_async_reset", out_vec(), 0);
    model_reset();
    repeat (2) apply(1, 1, 0, 0);
    reset = 1'b1;
    n_tick = 0;
    repeat (12) apply(1, 1, 0, 0);
    check("h3_no_tick", n_tick, 0);
    check("h3_idle", int'(bus.state), 0);
    repeat (6) apply(0, 1, 0, 0);
    n_tick = 0;
    repeat (12) apply(1, 1, 0, 0);
    check("h3_ticks_after_press", n_tick, 3);

    // Randomized stimulus against the model.
    r_st = 1; r_pl = 1; r_sw = 0; r_cz = 0;
    h_st = 0; h_pl = 0; h_sw = 0; h_cz = 0;
    for (int c = 0; c < 3000; c++) begin
      if (h_st == 0) begin r_st = !r_st; h_st = $urandom_range(1, 8); end
      if (h_pl == 0) begin r_pl = !r_pl; h_pl = $urandom_range(1, 8); end
      if (h_sw == 0) begin r_sw = ($urandom_range(0, 3) == 0); h_sw = $urandom_range(10, 80); end
      if (h_cz == 0) begin r_cz = ($urandom_range(0, 9) < 3); h_cz = $urandom_range(5, 60); end
      h_st--; h_pl--; h_sw--; h_cz--;
      apply(r_st, r_pl, r_sw, r_cz);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
